m_axis: RTL and testbench

AXI-Stream master that drains the processing pipeline's output vectors onto an external stream. Each accepted pipeline vector is converted from internal to external word format and buffered in a small FIFO. It is then serialized into one or more TDATA beats, with TKEEP trimming on the final beat and TLAST on the last beat of the transfer. It sits at the pipeline tail, opposite the stream slave at the head, and reports completion through the block control interface.

---
 rtl/m_axis_pkg.sv | 49 ++++
 rtl/m_axis_serializer.sv | 107 ++++++++++
 rtl/m_axis.sv | 113 +++++++++++
 tb/tb_m_axis.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axis_pkg.sv
// Shared constants, FSM encodings and the internal-to-external word conversion
// for the AXI-Stream master at the tail of the processing pipeline.
package m_axis_pkg;

    localparam int C_VECT_SIZE         = 8;
    localparam int C_EXT_DATA_WORD_WDT = 16;
    localparam int C_INT_DATA_WORD_WDT = 24;
    localparam int C_INT_FRAC_WDT      = 4;
    localparam int C_INT_WHOLE_WDT     = C_INT_DATA_WORD_WDT - C_INT_FRAC_WDT;

    localparam int C_M_TDATA_WDT       = 64;
    localparam int C_M_TKEEP_WDT       = C_M_TDATA_WDT / 8;
    localparam int C_M_FIFO_DEPTH      = 8;

    localparam int C_LAST_WORDS_WDT    = $clog2(C_VECT_SIZE + 1);
    localparam int C_VECT_EXT_WDT      = C_VECT_SIZE * C_EXT_DATA_WORD_WDT;
    localparam int C_VECT_INT_WDT      = C_VECT_SIZE * C_INT_DATA_WORD_WDT;
    // FIFO entry: converted vector, last flag, valid-word count of the last vector
    localparam int C_M_FIFO_WDT        = C_VECT_EXT_WDT + 1 + C_LAST_WORDS_WDT;

    localparam int C_BEATS_PER_VECT    = C_VECT_EXT_WDT / C_M_TDATA_WDT;
    localparam int C_WORDS_PER_BEAT    = C_M_TDATA_WDT / C_EXT_DATA_WORD_WDT;
    localparam int C_BYTES_PER_WORD    = C_EXT_DATA_WORD_WDT / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Drop the fractional bits (floor) and saturate to the signed external range.
    function automatic logic signed [C_EXT_DATA_WORD_WDT-1:0] conv_int2ext(
        input logic signed [C_INT_DATA_WORD_WDT-1:0] w
    );
        logic signed [C_INT_WHOLE_WDT-1:0] whole;
        logic signed [C_INT_WHOLE_WDT-1:0] ext_max;
        logic signed [C_INT_WHOLE_WDT-1:0] ext_min;
        whole   = w[C_INT_DATA_WORD_WDT-1:C_INT_FRAC_WDT];
        ext_max = {{(C_INT_WHOLE_WDT-C_EXT_DATA_WORD_WDT+1){1'b0}}, {(C_EXT_DATA_WORD_WDT-1){1'b1}}};
        ext_min = {{(C_INT_WHOLE_WDT-C_EXT_DATA_WORD_WDT+1){1'b1}}, {(C_EXT_DATA_WORD_WDT-1){1'b0}}};
        if (whole > ext_max) begin
            return {1'b0, {(C_EXT_DATA_WORD_WDT-1){1'b1}}};
        end
        if (whole < ext_min) begin
            return {1'b1, {(C_EXT_DATA_WORD_WDT-1){1'b0}}};
        end
        return whole[C_EXT_DATA_WORD_WDT-1:0];
    endfunction

endpackage

// File: rtl/m_axis_serializer.sv
// Splits buffered vectors into TDATA beats. A vector stage holds the vector
// being sent; a registered output stage holds the beat on the bus, so TVALID
// never depends combinationally on TREADY and vectors follow without bubbles.
module m_axis_serializer
    import m_axis_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     fifo_vld_i,
    input  logic [C_M_FIFO_WDT-1:0]  fifo_data_i,
    output logic                     fifo_pop_o,
    output logic [C_M_TDATA_WDT-1:0] tdata_o,
    output logic [C_M_TKEEP_WDT-1:0] tkeep_o,
    output logic                     tlast_o,
    output logic                     tvalid_o,
    input  logic                     tready_i
);

    localparam int BEAT_W = (C_BEATS_PER_VECT > 1) ? $clog2(C_BEATS_PER_VECT) : 1;

    logic [C_VECT_EXT_WDT-1:0]   vec_q;
    logic                        last_q;
    logic [C_LAST_WORDS_WDT-1:0] lastw_q;
    logic                        have_q;
    logic [BEAT_W-1:0]           beat_q;
    logic [C_M_TDATA_WDT-1:0]    tdata_q;
    logic [C_M_TKEEP_WDT-1:0]    tkeep_q;
    logic                        tlast_q;
    logic                        tvalid_q;

    int                          n_beats;
    int                          keep_bytes;
    logic                        is_final;
    logic                        load_out;
    logic                        move;
    logic [C_M_TDATA_WDT-1:0]    beat_raw;
    logic [C_M_TDATA_WDT-1:0]    beat_data;
    logic [C_M_TKEEP_WDT-1:0]    beat_keep;

    // Beat selection, final-beat detection and TKEEP/TDATA trimming of the current beat
    always_comb begin
        n_beats = C_BEATS_PER_VECT;
        if (last_q) begin
            n_beats = (int'(lastw_q) + C_WORDS_PER_BEAT - 1) / C_WORDS_PER_BEAT;
        end
        if (n_beats < 1) begin
            n_beats = 1;
        end
        is_final   = (int'(beat_q) == n_beats - 1);
        keep_bytes = C_M_TKEEP_WDT;
        if (last_q && is_final) begin
            keep_bytes = (int'(lastw_q) - int'(beat_q) * C_WORDS_PER_BEAT) * C_BYTES_PER_WORD;
        end
        beat_raw  = vec_q[int'(beat_q) * C_M_TDATA_WDT +: C_M_TDATA_WDT];
        beat_keep = '0;
        beat_data = '0;
        for (int k = 0; k < C_M_TKEEP_WDT; k++) begin
            beat_keep[k]        = (k < keep_bytes);
            beat_data[k*8 +: 8] = beat_keep[k] ? beat_raw[k*8 +: 8] : 8'h00;
        end
        load_out   = !tvalid_q || tready_i;
        move       = load_out && have_q;
        fifo_pop_o = fifo_vld_i && (!have_q || (move && is_final));
    end

    // Vector-stage occupancy and beat counter; output beat register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            have_q   <= 1'b0;
            beat_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '1;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            if (fifo_pop_o) begin
                have_q <= 1'b1;
                beat_q <= '0;
            end else if (move && is_final) begin
                have_q <= 1'b0;
            end else if (move) begin
                beat_q <= beat_q + 1'b1;
            end
            if (load_out) begin
                tvalid_q <= have_q;
                tlast_q  <= have_q && last_q && is_final;
                if (have_q) begin
                    tdata_q <= beat_data;
                    tkeep_q <= beat_keep;
                end
            end
        end
    end

    // Vector payload captured from the FIFO head on pop
    always_ff @(posedge clk_i) begin
        if (fifo_pop_o) begin
            {lastw_q, last_q, vec_q} <= fifo_data_i;
        end
    end

    assign tdata_o  = tdata_q;
    assign tkeep_o  = tkeep_q;
    assign tlast_o  = tlast_q;
    assign tvalid_o = tvalid_q;

endmodule

// File: rtl/m_axis.sv
// AXI-Stream master at the pipeline tail: converts accepted vectors to the
// external word format, buffers them in a vector FIFO and streams them out
// through the serializer. Reports completion with a one-cycle done pulse.
module m_axis
    import m_axis_pkg::*;
(
    input  logic                        M_AXIS_ACLK,
    input  logic                        M_AXIS_ARESETN,
    output logic [C_M_TDATA_WDT-1:0]    M_AXIS_TDATA,
    output logic [C_M_TKEEP_WDT-1:0]    M_AXIS_TKEEP,
    output logic                        M_AXIS_TLAST,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    input  logic                        pipe_en_i,
    input  logic                        pipe_step_i,
    output logic                        pipe_stall_o,
    input  logic                        ctrl_start_i,
    output logic                        ctrl_done_o,
    input  logic [C_LAST_WORDS_WDT-1:0] stream_out_last_words,
    input  logic                        data_vect_val_i,
    input  logic [C_VECT_INT_WDT-1:0]   data_vect_words_i,
    input  logic                        data_vect_last_i
);

    localparam int AW = $clog2(C_M_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(C_M_FIFO_DEPTH);
    localparam logic [AW:0] STALL_CNT = (AW+1)'(C_M_FIFO_DEPTH - 1);

    logic [1:0]               state_q, state_d;
    logic [C_M_FIFO_WDT-1:0]  mem_q [C_M_FIFO_DEPTH];
    logic [AW-1:0]            wptr_q, rptr_q;
    logic [AW:0]              count_q, count_d;
    logic                     stall_q;

    logic [C_VECT_EXT_WDT-1:0] ext_vec;
    logic                      wr_req, wr_en, rd_en, full;
    logic                      tlast_hs;

    // Word conversion and FIFO write/read qualification
    always_comb begin
        ext_vec = '0;
        for (int i = 0; i < C_VECT_SIZE; i++) begin
            ext_vec[i*C_EXT_DATA_WORD_WDT +: C_EXT_DATA_WORD_WDT] =
                conv_int2ext(data_vect_words_i[i*C_INT_DATA_WORD_WDT +: C_INT_DATA_WORD_WDT]);
        end
        full     = (count_q == FULL_CNT);
        wr_req   = (state_q == S_BUSY) && pipe_step_i && data_vect_val_i;
        // A write into a full FIFO is only legal when the head leaves in the same cycle
        wr_en    = wr_req && (!full || rd_en);
        tlast_hs = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Transfer FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ctrl_start_i && pipe_en_i) state_d = S_BUSY;
            S_BUSY:  if (wr_en && data_vect_last_i) state_d = S_DRAIN;
            S_DRAIN: if (tlast_hs) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, FIFO pointers/occupancy and the registered stall
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stall_q <= (count_q >= STALL_CNT);
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // FIFO storage; data is not reset, occupancy alone defines validity
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) begin
            mem_q[wptr_q] <= {stream_out_last_words, data_vect_last_i, ext_vec};
        end
    end

    a_no_overflow: assert property (@(posedge M_AXIS_ACLK) disable iff (!M_AXIS_ARESETN)
        !(wr_req && full && !rd_en));

    m_axis_serializer u_ser (
        .clk_i       (M_AXIS_ACLK),
        .rst_ni      (M_AXIS_ARESETN),
        .fifo_vld_i  (count_q != '0),
        .fifo_data_i (mem_q[rptr_q]),
        .fifo_pop_o  (rd_en),
        .tdata_o     (M_AXIS_TDATA),
        .tkeep_o     (M_AXIS_TKEEP),
        .tlast_o     (M_AXIS_TLAST),
        .tvalid_o    (M_AXIS_TVALID),
        .tready_i    (M_AXIS_TREADY)
    );

    assign pipe_stall_o = stall_q;
    assign ctrl_done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_m_axis.sv
// Directed bench for m_axis: packing, TKEEP trimming, back-pressure, word
// saturation and reset in the middle of a packet.
module tb_m_axis;
    import m_axis_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tlast, tvalid, tready;
    logic         en, step, stall, start, done;
    logic [3:0]   lastw;
    logic         dval, dlast;
    logic [191:0] dwords;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_last_cyc = 0;
    logic [72:0] rx_q[$];
    int          rx_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m_axis dut (
        .M_AXIS_ACLK           (clk),
        .M_AXIS_ARESETN        (rst_n),
        .M_AXIS_TDATA          (tdata),
        .M_AXIS_TKEEP          (tkeep),
        .M_AXIS_TLAST          (tlast),
        .M_AXIS_TVALID         (tvalid),
        .M_AXIS_TREADY         (tready),
        .pipe_en_i             (en),
        .pipe_step_i           (step),
        .pipe_stall_o          (stall),
        .ctrl_start_i          (start),
        .ctrl_done_o           (done),
        .stream_out_last_words (lastw),
        .data_vect_val_i       (dval),
        .data_vect_words_i     (dwords),
        .data_vect_last_i      (dlast)
    );

    // Beat collector and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && tvalid && tready) begin
            rx_q.push_back({tlast, tkeep, tdata});
            rx_cyc.push_back(cyc);
            if (tlast) hs_last_cyc = cyc;
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [191:0] mk_vec(input logic [7:0] id);
        logic [191:0] w;
        for (int j = 0; j < 8; j++) w[j*24 +: 24] = {4'h0, id, 8'(j), 4'h0};
        return w;
    endfunction

    function automatic logic [72:0] exp_beat(input logic [7:0] id, input int b,
                                             input bit lst, input int k);
        logic [63:0] d;
        logic [7:0]  kp;
        int          n;
        n = lst ? (k + 3) / 4 : 2;
        for (int j = 0; j < 4; j++) begin
            d[j*16 +: 16] = (lst && (b*4 + j >= k)) ? 16'h0000 : {id, 8'(b*4 + j)};
            kp[j*2]       = !(lst && (b*4 + j >= k));
            kp[j*2+1]     = !(lst && (b*4 + j >= k));
        end
        return {(lst && b == n - 1), kp, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tready = 1'b0; en = 1'b0; step = 1'b0; start = 1'b0;
        dval = 1'b0; dlast = 1'b0; lastw = 4'd0; dwords = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_xfer();
        en = 1'b1; step = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [7:0] id, input bit lst, input int k,
                            input logic [191:0] words, output int wcyc);
        int n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        if (stall) begin
            miscompares++;
            $display("FAIL send_timeout: stall=%0b after %0d cycles, required 0", stall, n);
        end
        dval = 1'b1; dlast = lst; lastw = 4'(k); dwords = words;
        tick();
        wcyc = cyc;
        dval = 1'b0; dlast = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < bound) begin
            tick();
            n++;
        end
        vectors++;
        if (done_cnt == d0) begin
            miscompares++;
            $display("FAIL done_timeout: done pulses=%0d, required %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_reset();
        vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %0b exp 0", tvalid); end
        vectors++; if (tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast: got %0b exp 0", tlast); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %0b exp 0", done); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %0b exp 0", stall); end
        vectors++; if (tdata !== 64'h0) begin miscompares++; $display("FAIL rst_tdata: got %h exp 0", tdata); end
        vectors++; if (tkeep !== 8'hFF) begin miscompares++; $display("FAIL rst_tkeep: got %h exp ff", tkeep); end
    endtask

    task automatic test_back_to_back();
        int w1, wx;
        rx_q.delete(); rx_cyc.delete();
        tready = 1'b1;
        start_xfer();
        send_vec(8'h01, 1'b0, 8, mk_vec(8'h01), w1);
        send_vec(8'h02, 1'b0, 8, mk_vec(8'h02), wx);
        send_vec(8'h03, 1'b1, 8, mk_vec(8'h03), wx);
        wait_done(60);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_width: done=%0b one cycle later, exp 0", done); end
        vectors++;
        if (rx_q.size() != 6) begin
            miscompares++; $display("FAIL b2b_count: got %0d beats exp 6", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== {1'b0, 8'hFF, 64'h0103_0102_0101_0100})
                begin miscompares++; $display("FAIL b2b_beat0: got %h exp %h", rx_q[0], {1'b0, 8'hFF, 64'h0103_0102_0101_0100}); end
            vectors++;
            if (rx_q[5] !== {1'b1, 8'hFF, 64'h0307_0306_0305_0304})
                begin miscompares++; $display("FAIL b2b_beat5: got %h exp %h", rx_q[5], {1'b1, 8'hFF, 64'h0307_0306_0305_0304}); end
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (rx_q[i] !== exp_beat(8'(i/2 + 1), i % 2, i >= 4, 8))
                    begin miscompares++; $display("FAIL b2b_beat%0d: got %h exp %h", i, rx_q[i], exp_beat(8'(i/2 + 1), i % 2, i >= 4, 8)); end
            end
            vectors++;
            if (rx_cyc[0] != w1 + 2) begin miscompares++; $display("FAIL b2b_latency: first beat cycle %0d exp %0d", rx_cyc[0], w1 + 2); end
            vectors++;
            if (rx_cyc[5] != rx_cyc[0] + 5) begin miscompares++; $display("FAIL b2b_bubble: last beat cycle %0d exp %0d", rx_cyc[5], rx_cyc[0] + 5); end
            vectors++;
            if (done_cyc != hs_last_cyc + 1) begin miscompares++; $display("FAIL b2b_done_delay: done cycle %0d exp %0d", done_cyc, hs_last_cyc + 1); end
        end
    endtask

    task automatic test_partial();
        int wx;
        rx_q.delete(); rx_cyc.delete();
        tready = 1'b1;
        start_xfer();
        send_vec(8'h21, 1'b1, 5, mk_vec(8'h21), wx);
        wait_done(40);
        vectors++;
        if (rx_q.size() != 2) begin
            miscompares++; $display("FAIL k5_count: got %0d beats exp 2", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== {1'b0, 8'hFF, 64'h2103_2102_2101_2100})
                begin miscompares++; $display("FAIL k5_beat0: got %h exp %h", rx_q[0], {1'b0, 8'hFF, 64'h2103_2102_2101_2100}); end
            vectors++;
            if (rx_q[1] !== {1'b1, 8'h03, 64'h0000_0000_0000_2104})
                begin miscompares++; $display("FAIL k5_beat1: got %h exp %h", rx_q[1], {1'b1, 8'h03, 64'h0000_0000_0000_2104}); end
        end
        rx_q.delete(); rx_cyc.delete();
        start_xfer();
        send_vec(8'h22, 1'b1, 4, mk_vec(8'h22), wx);
        wait_done(40);
        vectors++;
        if (rx_q.size() != 1) begin
            miscompares++; $display("FAIL k4_count: got %0d beats exp 1", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== {1'b1, 8'hFF, 64'h2203_2202_2201_2200})
                begin miscompares++; $display("FAIL k4_beat0: got %h exp %h", rx_q[0], {1'b1, 8'hFF, 64'h2203_2202_2201_2200}); end
        end
    endtask

    task automatic test_saturation();
        int wx;
        logic [191:0] w;
        w = {24'h00001F, 24'hFFFFFF, 24'h000010, 24'hFFFFF0,
             24'h800000, 24'hF00000, 24'h123456, 24'h07FFFF};
        rx_q.delete(); rx_cyc.delete();
        tready = 1'b1;
        start_xfer();
        send_vec(8'h00, 1'b1, 8, w, wx);
        wait_done(40);
        vectors++;
        if (rx_q.size() != 2) begin
            miscompares++; $display("FAIL sat_count: got %0d beats exp 2", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== {1'b0, 8'hFF, 64'h8000_8000_7FFF_7FFF})
                begin miscompares++; $display("FAIL sat_beat0: got %h exp %h", rx_q[0], {1'b0, 8'hFF, 64'h8000_8000_7FFF_7FFF}); end
            vectors++;
            if (rx_q[1] !== {1'b1, 8'hFF, 64'h0001_FFFF_0001_FFFF})
                begin miscompares++; $display("FAIL sat_beat1: got %h exp %h", rx_q[1], {1'b1, 8'hFF, 64'h0001_FFFF_0001_FFFF}); end
        end
    endtask

    task automatic test_tready_toggle();
        int   wx;
        int   d0;
        logic pv, pr, pl;
        logic [63:0] pd;
        logic [7:0]  pk;
        rx_q.delete(); rx_cyc.delete();
        tready = 1'b0;
        d0 = done_cnt;
        start_xfer();
        fork
            begin
                for (int v = 0; v < 4; v++) send_vec(8'(8'h40 + v), v == 3, 7, mk_vec(8'(8'h40 + v)), wx);
            end
            begin
                pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pk = '0;
                for (int i = 0; i < 300 && done_cnt == d0; i++) begin
                    tready = (i % 2 == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
                    @(negedge clk);
                    if (pv && !pr) begin
                        vectors++;
                        if (tvalid !== 1'b1 || tdata !== pd || tkeep !== pk || tlast !== pl) begin
                            miscompares++;
                            $display("FAIL hold_stable: got v=%0b d=%h k=%h l=%0b exp v=1 d=%h k=%h l=%0b",
                                     tvalid, tdata, tkeep, tlast, pd, pk, pl);
                        end
                    end
                    pv = tvalid; pr = tready; pd = tdata; pk = tkeep; pl = tlast;
                    tick();
                end
            end
        join
        tready = 1'b1;
        vectors++;
        if (done_cnt == d0) begin miscompares++; $display("FAIL toggle_done: done pulses=0 exp 1"); end
        vectors++;
        if (rx_q.size() != 8) begin
            miscompares++; $display("FAIL toggle_count: got %0d beats exp 8", rx_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (rx_q[i] !== exp_beat(8'(8'h40 + i/2), i % 2, i >= 6, 7))
                    begin miscompares++; $display("FAIL toggle_beat%0d: got %h exp %h", i, rx_q[i], exp_beat(8'(8'h40 + i/2), i % 2, i >= 6, 7)); end
            end
            vectors++;
            if (rx_q[7][71:64] !== 8'h3F) begin miscompares++; $display("FAIL toggle_keep: got %h exp 3f", rx_q[7][71:64]); end
        end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        int wx;
        int acc = 0;
        rx_q.delete(); rx_cyc.delete();
        tready = 1'b0;
        start_xfer();
        fork
            begin
                for (int v = 0; v < 10; v++) begin
                    send_vec(8'(8'h50 + v), v == 9, 8, mk_vec(8'(8'h50 + v)), wx);
                    acc++;
                end
            end
            begin
                repeat (20) tick();
                vectors++;
                if (acc != 9) begin miscompares++; $display("FAIL bp_accepted: got %0d vectors exp 9", acc); end
                vectors++;
                if (stall !== 1'b1) begin miscompares++; $display("FAIL bp_stall: got %0b exp 1", stall); end
                tready = 1'b1;
            end
        join
        wait_done(100);
        vectors++;
        if (rx_q.size() != 20) begin
            miscompares++; $display("FAIL bp_count: got %0d beats exp 20", rx_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                vectors++;
                if (rx_q[i] !== exp_beat(8'(8'h50 + i/2), i % 2, i >= 18, 8))
                    begin miscompares++; $display("FAIL bp_beat%0d: got %h exp %h", i, rx_q[i], exp_beat(8'(8'h50 + i/2), i % 2, i >= 18, 8)); end
            end
        end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL bp_stall_release: got %0b exp 0", stall); end
    endtask

    task automatic test_reset_mid();
        int wx;
        rx_q.delete(); rx_cyc.delete();
        tready = 1'b0;
        start_xfer();
        send_vec(8'h60, 1'b0, 8, mk_vec(8'h60), wx);
        send_vec(8'h61, 1'b0, 8, mk_vec(8'h61), wx);
        repeat (3) tick();
        vectors++;
        if (tvalid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_tvalid: got %0b exp 1", tvalid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_async_tvalid: got %0b exp 0", tvalid); end
        vectors++;
        if (tkeep !== 8'hFF || tdata !== 64'h0 || tlast !== 1'b0)
            begin miscompares++; $display("FAIL mid_outputs: got k=%h d=%h l=%0b exp k=ff d=0 l=0", tkeep, tdata, tlast); end
        repeat (2) tick();
        rst_n = 1'b1;
        tready = 1'b1;
        dval = 1'b1; dlast = 1'b1; lastw = 4'd8; dwords = mk_vec(8'h6F);
        tick();
        dval = 1'b0; dlast = 1'b0;
        repeat (6) tick();
        vectors++;
        if (rx_q.size() != 0) begin miscompares++; $display("FAIL mid_flush: got %0d beats exp 0", rx_q.size()); end
        vectors++;
        if (done_cnt != 0 && done === 1'b1) begin miscompares++; $display("FAIL mid_done: got %0b exp 0", done); end
        start_xfer();
        send_vec(8'h62, 1'b1, 8, mk_vec(8'h62), wx);
        wait_done(40);
        vectors++;
        if (rx_q.size() != 2) begin
            miscompares++; $display("FAIL mid_restart_count: got %0d beats exp 2", rx_q.size());
        end else begin
            vectors++;
            if (rx_q[0] !== {1'b0, 8'hFF, 64'h6203_6202_6201_6200})
                begin miscompares++; $display("FAIL mid_restart_beat0: got %h exp %h", rx_q[0], {1'b0, 8'hFF, 64'h6203_6202_6201_6200}); end
            vectors++;
            if (rx_q[1] !== {1'b1, 8'hFF, 64'h6207_6206_6205_6204})
                begin miscompares++; $display("FAIL mid_restart_beat1: got %h exp %h", rx_q[1], {1'b1, 8'hFF, 64'h6207_6206_6205_6204}); end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_back_to_back();
        test_partial();
        test_saturation();
        test_tready_toggle();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
